// File: rtl/key_extract_pipe.sv
// Two-stage key extractor: S1 captures the PHV and its key selectors, S2 builds
// the match key from PHV containers plus predicate bits and registers it with the PHV.
module key_extract_pipe #(
  parameter int PHV_LEN  = 48*8+32*8+16*8+256,
  parameter int NUM_K6   = 2,
  parameter int NUM_K4   = 2,
  parameter int NUM_K2   = 2,
  parameter int NUM_PRED = 2,
  parameter int KEY_LEN  = 48*NUM_K6+32*NUM_K4+16*NUM_K2+NUM_PRED,
  parameter int KEY_OFF  = 3*(NUM_K6+NUM_K4+NUM_K2)+20*NUM_PRED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic               ready_out,
  input  logic               key_offset_valid,
  input  logic [KEY_OFF-1:0] key_offset_w,
  input  logic [KEY_LEN-1:0] key_mask_w,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid_out,
  output logic [KEY_LEN-1:0] key_out_masked,
  output logic               key_valid_out,
  input  logic               ready_in
);

  // Container groups sit MSB-first; index 7 is the top container of each group.
  localparam int C6_BASE = PHV_LEN - 48*8;
  localparam int C4_BASE = C6_BASE - 32*8;
  localparam int C2_BASE = C4_BASE - 16*8;
  localparam int K4_TOP  = KEY_LEN - 1 - 48*NUM_K6;
  localparam int K2_TOP  = K4_TOP - 32*NUM_K4;

  logic               en;
  logic               s1_valid;
  logic [PHV_LEN-1:0] s1_phv;
  logic [KEY_OFF-1:0] s1_off;
  logic [KEY_LEN-1:0] s1_mask;
  logic [KEY_LEN-1:0] key;

  function automatic logic [47:0] cont6(input logic [PHV_LEN-1:0] phv, input logic [2:0] idx);
    return phv[C6_BASE + 48*32'(idx) +: 48];
  endfunction

  function automatic logic [31:0] cont4(input logic [PHV_LEN-1:0] phv, input logic [2:0] idx);
    return phv[C4_BASE + 32*32'(idx) +: 32];
  endfunction

  function automatic logic [15:0] cont2(input logic [PHV_LEN-1:0] phv, input logic [2:0] idx);
    return phv[C2_BASE + 16*32'(idx) +: 16];
  endfunction

  // A container operand is the low byte of the selected container.
  function automatic logic [7:0] operand(input logic [PHV_LEN-1:0] phv,
                                         input logic [1:0] typ, input logic [2:0] idx);
    logic [47:0] c;
    case (typ)
      2'd0:    c = {32'd0, cont2(phv, idx)};
      2'd1:    c = {16'd0, cont4(phv, idx)};
      2'd2:    c = cont6(phv, idx);
      default: c = '0;
    endcase
    return c[7:0];
  endfunction

  function automatic logic pred_eval(input logic [PHV_LEN-1:0] phv, input logic [19:0] op);
    logic [7:0] a;
    logic [7:0] b;
    logic       r;
    a = op[17] ? op[16:9] : operand(phv, op[13:12], op[11:9]);
    b = op[8]  ? op[7:0]  : operand(phv, op[4:3], op[2:0]);
    case (op[19:18])
      2'b00:   r = (a > b);
      2'b01:   r = (a >= b);
      2'b10:   r = (a == b);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // A stall is only possible while the output register holds an unconsumed PHV.
  assign en            = ~phv_valid_out | ready_in;
  assign ready_out     = en;
  assign key_valid_out = phv_valid_out;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    key = '0;
    for (int j = 0; j < NUM_K6; j++)
      key[KEY_LEN-1-48*j -: 48] = cont6(s1_phv, s1_off[KEY_OFF-1-3*j -: 3]);
    for (int j = 0; j < NUM_K4; j++)
      key[K4_TOP-32*j -: 32] = cont4(s1_phv, s1_off[KEY_OFF-1-3*(NUM_K6+j) -: 3]);
    for (int j = 0; j < NUM_K2; j++)
      key[K2_TOP-16*j -: 16] = cont2(s1_phv, s1_off[KEY_OFF-1-3*(NUM_K6+NUM_K4+j) -: 3]);
    for (int p = 0; p < NUM_PRED; p++)
      key[p] = pred_eval(s1_phv, s1_off[20*p +: 20]);
  end

  // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_phv   <= '0;
      s1_off   <= '0;
      s1_mask  <= '0;
    end else if (en) begin
      s1_valid <= phv_valid_in;
      if (phv_valid_in) begin
        s1_phv  <= phv_in;
        // Without valid selectors the key is fully masked but the PHV still flows.
        s1_off  <= key_offset_valid ? key_offset_w : '0;
        s1_mask <= key_offset_valid ? key_mask_w : '1;
      end
    end
  end

  // NOTE: the wide data registers are reset too, so nothing stale is visible after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_valid_out  <= 1'b0;
      phv_out        <= '0;
      key_out_masked <= '0;
    end else if (en) begin
      phv_valid_out <= s1_valid;
      if (s1_valid) begin
        phv_out        <= s1_phv;
        key_out_masked <= key & ~s1_mask;
      end
    end
  end

endmodule

// File: tb/tb_key_extract_pipe.sv
// Directed bench for key_extract_pipe: expected PHV/key pushed on accept,
// popped and compared when the DUT hands a result downstream.
module tb_key_extract_pipe;

  localparam int PL = 1024;
  localparam int KL = 194;
  localparam int KO = 58;
  localparam logic [19:0] P_ONE = 20'hC0000;

  typedef struct {
    logic [PL-1:0] phv;
    logic [KL-1:0] key;
    int            acc_cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [PL-1:0] phv_in;
  logic          phv_valid_in;
  logic          ready_out;
  logic          key_offset_valid;
  logic [KO-1:0] key_offset_w;
  logic [KL-1:0] key_mask_w;
  logic [PL-1:0] phv_out;
  logic          phv_valid_out;
  logic [KL-1:0] key_out_masked;
  logic          key_valid_out;
  logic          ready_in;

  key_extract_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .ready_out        (ready_out),
    .key_offset_valid (key_offset_valid),
    .key_offset_w     (key_offset_w),
    .key_mask_w       (key_mask_w),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .key_out_masked   (key_out_masked),
    .key_valid_out    (key_valid_out),
    .ready_in         (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_lat = 0;
  exp_t q[$];
  int   pop_cyc[$];
  exp_t cur_exp;

  logic [47:0]  c6 [8];
  logic [31:0]  c4 [8];
  logic [15:0]  c2 [8];
  logic [255:0] meta;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_phv(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s[%0d]", tag, k), obs[256*k +: 256], exp[256*k +: 256]);
  endtask

  task automatic rand_cont();
    for (int i = 0; i < 8; i++) begin
      c6[i] = {16'($urandom), $urandom};
      c4[i] = $urandom;
      c2[i] = 16'($urandom);
    end
    meta = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [PL-1:0] build_phv();
    return {c6[7], c6[6], c6[5], c6[4], c6[3], c6[2], c6[1], c6[0],
            c4[7], c4[6], c4[5], c4[4], c4[3], c4[2], c4[1], c4[0],
            c2[7], c2[6], c2[5], c2[4], c2[3], c2[2], c2[1], c2[0], meta};
  endfunction

  function automatic logic [KL-1:0] rand_mask();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[KL-1:0];
  endfunction

  function automatic logic [KO-1:0] mk_off(input int a6, input int b6, input int a4, input int b4,
                                           input int a2, input int b2,
                                           input logic [19:0] p1, input logic [19:0] p0);
    return {3'(a6), 3'(b6), 3'(a4), 3'(b4), 3'(a2), 3'(b2), p1, p0};
  endfunction

  function automatic logic [KL-1:0] ekey(input int a6, input int b6, input int a4, input int b4,
                                         input int a2, input int b2,
                                         input logic [1:0] pr, input logic [KL-1:0] mask);
    return {c6[a6], c6[b6], c4[a4], c4[b4], c2[a2], c2[b2], pr} & ~mask;
  endfunction

  // op1 from a container, op2 immediate
  function automatic logic [19:0] op_ci(input logic [1:0] opc, input logic [1:0] typ,
                                        input logic [2:0] idx, input logic [7:0] imm);
    return {opc, 1'b0, 3'b000, typ, idx, 1'b1, imm};
  endfunction

  // op1 immediate, op2 from a container
  function automatic logic [19:0] op_ic(input logic [1:0] opc, input logic [7:0] imm,
                                        input logic [1:0] typ, input logic [2:0] idx);
    return {opc, 1'b1, imm, 1'b0, 3'b000, typ, idx};
  endfunction

  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = phv_valid_in && ready_out;
    if (acc) begin
      cur_exp.acc_cyc = cyc;
      q.push_back(cur_exp);
    end
    if (phv_valid_out && ready_in) begin
      check("out_expected", 256'(q.size() != 0), 256'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("key_out", 256'(key_out_masked), 256'(e.key));
        check("key_valid", 256'(key_valid_out), 256'(1));
        check_phv("phv_out", phv_out, e.phv);
        last_lat = cyc - e.acc_cyc;
        pop_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [PL-1:0] phv, input logic [KO-1:0] off,
                      input logic [KL-1:0] mask, input logic kv, input logic [KL-1:0] exp_key);
    bit acc;
    int n;
    phv_in           = phv;
    key_offset_w     = off;
    key_mask_w       = mask;
    key_offset_valid = kv;
    phv_valid_in     = 1'b1;
    cur_exp.phv      = phv;
    cur_exp.key      = exp_key;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    check("accept", 256'(acc), 256'(1));
    phv_valid_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick(acc);
      n++;
    end
    check("drain", 256'(q.size()), 256'(0));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
    check("idle_valid", 256'(phv_valid_out), 256'(0));
  endtask

  initial begin
    logic [PL-1:0] phv;
    logic [KL-1:0] m;
    bit            acc;

    rst_n            = 1'b0;
    phv_in           = '0;
    phv_valid_in     = 1'b0;
    key_offset_valid = 1'b0;
    key_offset_w     = '0;
    key_mask_w       = '0;
    ready_in         = 1'b1;

    // Reset state
    #2;
    check("rst_valid", 256'(phv_valid_out), 256'(0));
    check("rst_key_valid", 256'(key_valid_out), 256'(0));
    check("rst_key", 256'(key_out_masked), 256'(0));
    check("rst_ready", 256'(ready_out), 256'(1));
    check_phv("rst_phv", phv_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single PHV: 6B field 0 selects container 3, two-cycle latency
    rand_cont();
    c6[3] = 48'h0A0B0C0D0E0F;
    send(build_phv(), mk_off(3, 0, 1, 2, 3, 4, P_ONE, P_ONE), '0, 1'b1,
         ekey(3, 0, 1, 2, 3, 4, 2'b11, '0));
    drain(10);
    check("latency", 256'(last_lat), 256'(2));

    // Back-to-back A, B, C with varied selectors and masks
    pop_cyc.delete();
    rand_cont();
    send(build_phv(), mk_off(7, 6, 5, 4, 3, 2, P_ONE, P_ONE), '0, 1'b1,
         ekey(7, 6, 5, 4, 3, 2, 2'b11, '0));
    rand_cont();
    m = rand_mask();
    send(build_phv(), mk_off(0, 7, 0, 7, 0, 7, P_ONE, P_ONE), m, 1'b1,
         ekey(0, 7, 0, 7, 0, 7, 2'b11, m));
    rand_cont();
    send(build_phv(), mk_off(2, 2, 6, 1, 5, 5, P_ONE, P_ONE), '0, 1'b1,
         ekey(2, 2, 6, 1, 5, 5, 2'b11, '0));
    drain(10);
    check("b2b_count", 256'(pop_cyc.size()), 256'(3));
    if (pop_cyc.size() == 3) begin
      check("b2b_gap_ab", 256'(pop_cyc[1] - pop_cyc[0]), 256'(1));
      check("b2b_gap_bc", 256'(pop_cyc[2] - pop_cyc[1]), 256'(1));
    end
    idle(3);

    // Backpressure: A at the output, B in S1, downstream stalls for 4 cycles
    pop_cyc.delete();
    rand_cont();
    send(build_phv(), mk_off(1, 2, 3, 4, 5, 6, P_ONE, P_ONE), '0, 1'b1,
         ekey(1, 2, 3, 4, 5, 6, 2'b11, '0));
    rand_cont();
    m = rand_mask();
    send(build_phv(), mk_off(6, 5, 4, 3, 2, 1, P_ONE, P_ONE), m, 1'b1,
         ekey(6, 5, 4, 3, 2, 1, 2'b11, m));
    ready_in = 1'b0;
    check("stall_inflight", 256'(q.size()), 256'(2));
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_ready", 256'(ready_out), 256'(0));
      check("stall_valid", 256'(phv_valid_out), 256'(1));
      if (q.size() != 0) begin
        check("stall_key", 256'(key_out_masked), 256'(q[0].key));
        check_phv("stall_phv", phv_out, q[0].phv);
      end
      tick(acc);
    end
    ready_in = 1'b1;
    drain(10);
    check("stall_count", 256'(pop_cyc.size()), 256'(2));
    if (pop_cyc.size() == 2)
      check("stall_gap", 256'(pop_cyc[1] - pop_cyc[0]), 256'(1));
    idle(3);

    // Predicates: cont_2B[1] low byte 8'h10 against immediate 8'h10, all opcodes
    rand_cont();
    c2[1] = 16'hAB10;
    c4[6] = {24'h123456, 8'h2F};
    c6[4] = {40'h9876543210, 8'h80};
    phv = build_phv();
    send(phv, mk_off(1, 5, 2, 7, 0, 6, P_ONE, op_ci(2'b00, 2'd0, 3'd1, 8'h10)), '0, 1'b1,
         ekey(1, 5, 2, 7, 0, 6, 2'b10, '0));
    send(phv, mk_off(1, 5, 2, 7, 0, 6, P_ONE, op_ci(2'b01, 2'd0, 3'd1, 8'h10)), '0, 1'b1,
         ekey(1, 5, 2, 7, 0, 6, 2'b11, '0));
    send(phv, mk_off(1, 5, 2, 7, 0, 6, P_ONE, op_ci(2'b10, 2'd0, 3'd1, 8'h10)), '0, 1'b1,
         ekey(1, 5, 2, 7, 0, 6, 2'b11, '0));
    send(phv, mk_off(1, 5, 2, 7, 0, 6, P_ONE, op_ci(2'b11, 2'd0, 3'd1, 8'h10)), '0, 1'b1,
         ekey(1, 5, 2, 7, 0, 6, 2'b11, '0));
    // type 3 reads as zero; immediate op1 vs 4B container low byte 8'h2F
    send(phv, mk_off(4, 3, 6, 0, 1, 2, op_ic(2'b00, 8'h30, 2'd1, 3'd6),
                     op_ci(2'b10, 2'd3, 3'd1, 8'h00)), '0, 1'b1,
         ekey(4, 3, 6, 0, 1, 2, 2'b11, '0));
    // unsigned compare on a 6B container (8'h80 > 8'h7F); 8'h10 >= 8'h11 is false
    send(phv, mk_off(4, 3, 6, 0, 1, 2, op_ci(2'b01, 2'd0, 3'd1, 8'h11),
                     op_ci(2'b00, 2'd2, 3'd4, 8'h7F)), '0, 1'b1,
         ekey(4, 3, 6, 0, 1, 2, 2'b01, '0));
    drain(12);

    // Offsets not valid: key fully cleared, PHV still passes
    rand_cont();
    send(build_phv(), mk_off(5, 5, 5, 5, 5, 5, P_ONE, P_ONE), '0, 1'b0, '0);
    drain(10);
    idle(2);

    // Reset with two PHVs in flight
    rand_cont();
    send(build_phv(), mk_off(0, 1, 2, 3, 4, 5, P_ONE, P_ONE), '0, 1'b1,
         ekey(0, 1, 2, 3, 4, 5, 2'b11, '0));
    rand_cont();
    send(build_phv(), mk_off(5, 4, 3, 2, 1, 0, P_ONE, P_ONE), '0, 1'b1,
         ekey(5, 4, 3, 2, 1, 0, 2'b11, '0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 256'(phv_valid_out), 256'(0));
    check("mid_rst_key_valid", 256'(key_valid_out), 256'(0));
    check("mid_rst_key", 256'(key_out_masked), 256'(0));
    check_phv("mid_rst_phv", phv_out, '0);
    q.delete();
    @(negedge clk);
    tick(acc);
    rst_n = 1'b1;
    idle(4);

    // First PHV after reset behaves as from idle
    rand_cont();
    m = rand_mask();
    send(build_phv(), mk_off(7, 0, 7, 0, 7, 0, P_ONE, P_ONE), m, 1'b1,
         ekey(7, 0, 7, 0, 7, 0, 2'b11, m));
    drain(10);
    check("post_rst_latency", 256'(last_lat), 256'(2));
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
